// File: rtl/reservation_station.sv
// Reservation station: buffers issued ops, snoops both CDBs, dispatches the lowest ready entry; issue->dispatch 1 cycle min.
// Backpressure: rs_full is a combinational credit to issue; rdy_in=0 freezes all state and forces ex_valid low.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op_type,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qj_busy,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [TAG_W-1:0]  issue_rob_tag,
  output logic              rs_full,
  input  logic              cdb_alu_valid,
  input  logic [TAG_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_data,
  input  logic              cdb_lsb_valid,
  input  logic [TAG_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_data,
  output logic              ex_valid,
  output logic [OP_W-1:0]   op_type_ex,
  output logic [DATA_W-1:0] rs1_data_ex,
  output logic [DATA_W-1:0] rs2_data_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [TAG_W-1:0]  tag_in_rob
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic              qj_busy;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic              qk_busy;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  rob_tag;
  } entry_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] ready;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  entry_t             new_ent;
  logic               disp_any;
  logic [IDX_W-1:0]   disp_idx, free_idx;

  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   op_ex_q, op_ex_d;
  logic [DATA_W-1:0] rs1_ex_q, rs1_ex_d;
  logic [DATA_W-1:0] rs2_ex_q, rs2_ex_d;
  logic [DATA_W-1:0] imm_ex_q, imm_ex_d;
  logic [DATA_W-1:0] pc_ex_q, pc_ex_d;
  logic [TAG_W-1:0]  tag_ex_q, tag_ex_d;

  // Returns {still_busy, value}; ALU broadcast takes priority over LSB on a double match.
  function automatic logic [DATA_W:0] wake(input logic busy, input logic [TAG_W-1:0] q,
                                           input logic [DATA_W-1:0] v);
    logic [DATA_W:0] r;
    r = {busy, v};
    if (busy && cdb_alu_valid && cdb_alu_tag == q)      r = {1'b0, cdb_alu_data};
    else if (busy && cdb_lsb_valid && cdb_lsb_tag == q) r = {1'b0, cdb_lsb_data};
    return r;
  endfunction

  assign rs_full = &busy_q;

  always_comb begin
    ready    = '0;
    disp_any = 1'b0;
    disp_idx = '0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
      if (ready[i]) begin
        disp_any = 1'b1;
        disp_idx = IDX_W'(i);
      end
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.op      = issue_op_type;
    new_ent.qj      = issue_qj;
    new_ent.qk      = issue_qk;
    new_ent.imm     = issue_imm;
    new_ent.pc      = issue_pc;
    new_ent.rob_tag = issue_rob_tag;
    {new_ent.qj_busy, new_ent.vj} = wake(issue_qj_busy, issue_qj, issue_vj);
    {new_ent.qk_busy, new_ent.vk} = wake(issue_qk_busy, issue_qk, issue_vk);
  end

  always_comb begin
    busy_d     = busy_q;
    ent_d      = ent_q;
    ex_valid_d = 1'b0;
    op_ex_d    = '0;
    rs1_ex_d   = '0;
    rs2_ex_d   = '0;
    imm_ex_d   = '0;
    pc_ex_d    = '0;
    tag_ex_d   = '0;
    if (rdy_in) begin
      if (clear_in) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            {ent_d[i].qj_busy, ent_d[i].vj} = wake(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].qk_busy, ent_d[i].vk} = wake(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
          end
        end
        if (disp_any) begin
          busy_d[disp_idx] = 1'b0;
          ex_valid_d       = 1'b1;
          op_ex_d          = ent_q[disp_idx].op;
          rs1_ex_d         = ent_q[disp_idx].vj;
          rs2_ex_d         = ent_q[disp_idx].vk;
          imm_ex_d         = ent_q[disp_idx].imm;
          pc_ex_d          = ent_q[disp_idx].pc;
          tag_ex_d         = ent_q[disp_idx].rob_tag;
        end
        // free_idx is never the dispatching entry, so a freed slot waits one edge for reuse
        if (issue_valid && !rs_full) begin
          busy_d[free_idx] = 1'b1;
          ent_d[free_idx]  = new_ent;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      ex_valid_q <= 1'b0;
      op_ex_q    <= '0;
      rs1_ex_q   <= '0;
      rs2_ex_q   <= '0;
      imm_ex_q   <= '0;
      pc_ex_q    <= '0;
      tag_ex_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      ex_valid_q <= ex_valid_d;
      op_ex_q    <= op_ex_d;
      rs1_ex_q   <= rs1_ex_d;
      rs2_ex_q   <= rs2_ex_d;
      imm_ex_q   <= imm_ex_d;
      pc_ex_q    <= pc_ex_d;
      tag_ex_q   <= tag_ex_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign op_type_ex  = op_ex_q;
  assign rs1_data_ex = rs1_ex_q;
  assign rs2_data_ex = rs2_ex_q;
  assign imm_ex      = imm_ex_q;
  assign pc_ex       = pc_ex_q;
  assign tag_in_rob  = tag_ex_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected dispatches (with their edge number) are queued at stimulus time.
module tb_reservation_station;

  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_W8   = 6'd2;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clear_in;
  logic        issue_valid, issue_qj_busy, issue_qk_busy;
  logic [5:0]  issue_op_type;
  logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
  logic [3:0]  issue_qj, issue_qk, issue_rob_tag;
  logic        rs_full;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
  logic [31:0] cdb_alu_data, cdb_lsb_data;
  logic        ex_valid;
  logic [5:0]  op_type_ex;
  logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
  logic [3:0]  tag_in_rob;

  typedef struct {
    int          cyc;
    logic [5:0]  op;
    logic [31:0] rs1, rs2, imm, pc;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  reservation_station dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op_type(issue_op_type),
    .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_tag(issue_rob_tag),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_data(cdb_alu_data),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_data(cdb_lsb_data),
    .ex_valid(ex_valid), .op_type_ex(op_type_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .pc_ex(pc_ex), .tag_in_rob(tag_in_rob)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected dispatch lands two edges after the negedge at which it is pushed.
  task automatic push_exp(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                          input int delay);
    exp_t e;
    e.cyc = cyc + delay; e.op = op; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.pc = pc; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] vj, input logic qjb,
                             input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                             input logic [3:0] qk, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [3:0] tag);
    issue_valid = 1'b1; issue_op_type = op;
    issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
    issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk;
    issue_imm = imm; issue_pc = pc; issue_rob_tag = tag;
  endtask

  task automatic alu(input logic [3:0] tag, input logic [31:0] data);
    cdb_alu_valid = 1'b1; cdb_alu_tag = tag; cdb_alu_data = data;
  endtask

  task automatic lsb(input logic [3:0] tag, input logic [31:0] data);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = tag; cdb_lsb_data = data;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_in);
      issue_valid = 1'b0; cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; clear_in = 1'b0;
    end
  endtask

  always @(negedge clk_in) begin : mon
    exp_t e;
    if (rst_n_in) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("late_dispatch", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (ex_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_dispatch", 64'(ex_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("disp_cycle", 64'(cyc), 64'(e.cyc));
          chk("op_type_ex", 64'(op_type_ex), 64'(e.op));
          chk("rs1_data_ex", 64'(rs1_data_ex), 64'(e.rs1));
          chk("rs2_data_ex", 64'(rs2_data_ex), 64'(e.rs2));
          chk("imm_ex", 64'(imm_ex), 64'(e.imm));
          chk("pc_ex", 64'(pc_ex), 64'(e.pc));
          chk("tag_in_rob", 64'(tag_in_rob), 64'(e.tag));
        end
      end else begin
        chk("idle_op_nop", 64'(op_type_ex), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    issue_valid = 1'b0; issue_op_type = '0; issue_vj = '0; issue_qj_busy = 1'b0; issue_qj = '0;
    issue_vk = '0; issue_qk_busy = 1'b0; issue_qk = '0; issue_imm = '0; issue_pc = '0;
    issue_rob_tag = '0;
    cdb_alu_valid = 1'b0; cdb_alu_tag = '0; cdb_alu_data = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_tag = '0; cdb_lsb_data = '0;
    #2;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_op", 64'(op_type_ex), 64'd0);
    chk("rst_rs1", 64'(rs1_data_ex), 64'd0);
    chk("rst_tag", 64'(tag_in_rob), 64'd0);
    chk("rst_full", 64'(rs_full), 64'd0);
    step(2);
    rst_n_in = 1'b1;
    step(1);

    // 1: no dependencies, dispatch on the next edge
    drive_issue(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 32'h100, 4'd2);
    push_exp(OP_ADDI, 32'd5, 32'd0, 32'd3, 32'h100, 4'd2, 2);
    step(2);
    step(1);
    chk("t1_idle_valid", 64'(ex_valid), 64'd0);
    chk("t1_idle_op", 64'(op_type_ex), 64'd0);

    // 2: rs1 waits on tag 7, woken by ALU CDB three cycles later
    drive_issue(OP_ADD, 32'd0, 1'b1, 4'd7, 32'd20, 1'b0, 4'd0, 32'd0, 32'h104, 4'd3);
    step(3);
    alu(4'd7, 32'h10);
    push_exp(OP_ADD, 32'h10, 32'd20, 32'd0, 32'h104, 4'd3, 2);
    step(3);

    // 3: same-cycle forwarding from LSB CDB into rs2
    drive_issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'd0, 32'h108, 4'd5);
    lsb(4'd4, 32'd9);
    push_exp(OP_ADD, 32'd1, 32'd9, 32'd0, 32'h108, 4'd5, 2);
    step(3);

    // Stall: issue ignored while rdy_in is low
    rdy_in = 1'b0;
    drive_issue(OP_ADDI, 32'd77, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 32'h10c, 4'd6);
    step(1);
    rdy_in = 1'b1;
    step(3);

    // Stall delays a pending dispatch by one edge
    drive_issue(OP_ADDI, 32'd8, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd4, 32'h110, 4'd1);
    step(1);
    push_exp(OP_ADDI, 32'd8, 32'd0, 32'd4, 32'h110, 4'd1, 2);
    rdy_in = 1'b0;
    step(1);
    rdy_in = 1'b1;
    step(2);

    // 4: fill all 16 entries, each waiting on its own tag
    for (int i = 0; i < 16; i++) begin
      drive_issue(OP_W8, 32'd0, 1'b1, 4'(i), 32'(i), 1'b0, 4'd0, 32'(i), 32'(i * 4), 4'(i));
      step(1);
    end
    chk("t4_full", 64'(rs_full), 64'd1);
    drive_issue(OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h200, 4'd8);
    step(3);
    chk("t4_still_full", 64'(rs_full), 64'd1);
    alu(4'd0, 32'hAA);
    push_exp(OP_W8, 32'hAA, 32'd0, 32'd0, 32'd0, 4'd0, 2);
    step(1);
    chk("t4_full_woken", 64'(rs_full), 64'd1);
    step(1);
    chk("t4_full_drop", 64'(rs_full), 64'd0);
    step(1);

    // 5: entries 3 and 9 ready together; lower index first
    alu(4'd3, 32'h33);
    lsb(4'd9, 32'h99);
    push_exp(OP_W8, 32'h33, 32'd3, 32'd3, 32'd12, 4'd3, 2);
    push_exp(OP_W8, 32'h99, 32'd9, 32'd9, 32'd36, 4'd9, 3);
    step(4);

    // 6: refill free slots 0, 3, 9, then flush (clear beats a same-cycle wake)
    for (int i = 0; i < 3; i++) begin
      drive_issue(OP_W8, 32'd0, 1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h300, 4'd0);
      step(1);
    end
    chk("t6_full", 64'(rs_full), 64'd1);
    clear_in = 1'b1;
    alu(4'd5, 32'h55);
    step(1);
    chk("t6_clr_full", 64'(rs_full), 64'd0);
    chk("t6_clr_valid", 64'(ex_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      alu(4'(i), 32'hDEAD);
      step(1);
    end
    step(2);

    // Async reset right after a dispatch edge
    drive_issue(OP_ADDI, 32'h44, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7, 32'h400, 4'd12);
    push_exp(OP_ADDI, 32'h44, 32'd0, 32'd7, 32'h400, 4'd12, 2);
    step(2);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_op", 64'(op_type_ex), 64'd0);
    chk("arst_rs1", 64'(rs1_data_ex), 64'd0);
    chk("arst_imm", 64'(imm_ex), 64'd0);
    chk("arst_pc", 64'(pc_ex), 64'd0);
    chk("arst_tag", 64'(tag_in_rob), 64'd0);
    step(1);
    rst_n_in = 1'b1;
    chk("arst_full", 64'(rs_full), 64'd0);
    step(3);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
